spi_target: RTL and testbench
=============================

# spi_target

Byte-oriented SPI target (responder) for mode 0 (CPOL=0, CPHA=0), MSB-first. It is the far end of the system's SPI controllers and lets a controller drive pins directly through the pinmux in loopback and self-test builds. SCK, CS_N and COPI are oversampled in the system clock domain. Received bytes are presented on a ready/valid stream, and transmit bytes are taken from a single-entry ready/valid holding register.

## Interface
Parameters:
- `TxFill`, default 8'hFF: byte shifted out when no transmit byte is available.
- `RxFifoDepth`, default 4: RX FIFO entries; used only when `SPI_TARGET_RX_FIFO_EN` is defined; must be a power of 2, ≥2.

Ports:
- `clk_i`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `rst_ni`  in  1  asynchronous active-low reset.
- `spi_sck_i`  in  1  raw SCK from pin.
- `spi_cs_ni`  in  1  raw chip select from pin, active low.
- `spi_copi_i`  in  1  raw COPI from pin.
- `spi_cipo_o`  out  1  CIPO data.
- `spi_cipo_en_o`  out  1  CIPO output enable; high only while selected.
- `rx_data_o`  out  8  received byte.
- `rx_valid_o`  out  1  `rx_data_o` valid.
- `rx_ready_i`  in  1  consumer accepts the byte.
- `rx_overrun_o`  out  1  one-cycle pulse; a byte was dropped.
- `tx_data_i`  in  8  next byte to transmit.
- `tx_valid_i`  in  1  `tx_data_i` valid.
- `tx_ready_o`  out  1  transmit holding register empty.
- `tx_underrun_o`  out  1  one-cycle pulse; `TxFill` was loaded.
- `abort_o`  out  1  one-cycle pulse; CS_N deasserted with bit count ≠ 0.
- `active_o`  out  1  synchronised select is asserted.

## Operation
- **Input synchronisation.** SCK, CS_N and COPI each pass through 2 flops (s1, s2). A third flop (s3) on SCK and CS_N provides edge detection: `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- **States.**
  - IDLE to SEL on a CS_N fall. In the same cycle: bit counter := 0, TX shift register := holding register (or `TxFill`).
  - SEL to IDLE on a CS_N rise.
- **Receive.** On an SCK rise in SEL, RX shift := {shift[6:0], copi_s2} and the 3-bit counter increments. When the counter wraps 7→0, the byte is pushed to the RX stage.
- **Transmit.** On an SCK fall in SEL:
  - If the counter is 0, a byte boundary has been reached: load the next byte.
  - Otherwise, shift left.
  - `spi_cipo_o` is always TX shift[7].
- **TX load rule.** If the holding register is full, take it and set `tx_ready_o` high the next cycle. If it is empty, load `TxFill` and pulse `tx_underrun_o`.
- **TX holding register.** Captures `tx_data_i` when `tx_valid_i && tx_ready_o`. If a capture and a load happen in the same cycle, the load takes the old contents and the capture fills the register, so `tx_ready_o` stays low.
- **RX stage.** Without the FIFO it is a single holding register. `rx_valid_o` stays high until `rx_ready_i`. A push while full drops the new byte and pulses `rx_overrun_o`. A push and a pop in the same cycle both succeed.
- **Abort.** A CS_N rise with counter ≠ 0 discards the partial byte, pulses `abort_o`, and resets the counter. Any TX byte already loaded is discarded and not re-queued.
- **CS_N precedence.** If CS_N rises in the same cycle as an SCK edge, CS_N wins and the SCK edge is ignored.
- **Reset.** Asserting reset mid-transfer clears all state. Reset values:
  - `spi_cipo_o` = 1, `spi_cipo_en_o` = 0
  - `rx_data_o` = 0, `rx_valid_o` = 0
  - `tx_ready_o` = 1, `active_o` = 0
  - all pulse outputs = 0
  - TX shift register = `TxFill`

## Timing
- Pin-to-detect latency is 2 `clk_i` cycles. The shift occurs on the 3rd `clk_i` edge after the first edge that samples the new pin value.
- `rx_valid_o` rises 1 cycle after the 8th-bit shift, i.e. 4 edges after the 8th SCK rise is first sampled.
- CIPO changes 3 `clk_i` edges after an SCK fall is first sampled. `spi_cipo_en_o` rises 3 edges after the CS_N fall.
- Maximum SCK frequency is `clk_i`/8. Minimum CS_N-fall to first SCK-rise is 4 `clk_i` cycles.
- Glitches shorter than 1 cycle may be missed. This is not a supported condition.

## Configuration
- `SPI_TARGET_RX_FIFO_EN` defined: the RX stage is an `RxFifoDepth`-entry FIFO with first-word fall-through. `rx_valid_o` means not empty. Overrun occurs only when the FIFO is full.
- Undefined: single-entry holding register as described above; `RxFifoDepth` is ignored.

## Structure
- **`spi_target_pkg`:** `SpiByteW` = 8, `SpiSyncStages` = 2, and the `spi_target_state_e` enum {IDLE, SEL}.
- **`spi_target_fifo`:** a separate sub-module, instantiated only under the macro. It has ready/valid push and pop, pointers one bit wider than the address, and a 2-port register array.

## Test plan
- **Basic transfer.** Preload `tx_data_i`=8'hA5, then send 8'h3C at `clk_i`/8 in one CS frame → `rx_data_o`=8'h3C with one `rx_valid_o`; sampled CIPO = 8'hA5; `tx_ready_o` high after the load.
- **Back-to-back underrun.** Send 3 bytes 8'h01, 8'h02, 8'h03 with only 8'h11 queued → CIPO reads 8'h11, 8'hFF, 8'hFF; `tx_underrun_o` pulses twice; RX sees 01, 02, 03 in order.
- **Overrun.** Hold `rx_ready_i` low and send 2 bytes (no FIFO) or 5 bytes (FIFO, depth 4) → exactly one `rx_overrun_o` pulse; the first byte(s) are retained and the last byte is dropped.
- **Mid-byte abort.** Deassert CS_N after 5 SCK edges → `abort_o` pulses once, no `rx_valid_o`; the next full frame receiving 8'hC3 is correct.
- **Reset mid-transfer.** Assert `rst_ni` low after bit 3 → all outputs at their reset values in the same cycle; the next frame operates normally.
- **Simultaneous events.** Push and pop on the RX stage in the same cycle, and capture and load on the TX holding register in the same cycle → no byte lost or duplicated.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared widths, synchroniser depth and FSM encoding for the spi_target block.
package spi_target_pkg;

  localparam int unsigned SpiByteW      = 8;
  localparam int unsigned SpiSyncStages = 2;
  localparam int unsigned SpiCntW       = $clog2(SpiByteW);

  typedef enum logic {
    IDLE = 1'b0,
    SEL  = 1'b1
  } spi_target_state_e;

endpackage

// File: rtl/spi_target_fifo.sv
// First-word fall-through RX FIFO for spi_target; Depth must be a power of 2 and at least 2.
module spi_target_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  output logic [Width-1:0] rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             empty, full, push, pop;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AddrW] != rptr_q[AddrW]) &&
               (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    rvalid_o = !empty;
    // A pop in the same cycle frees the slot being written, so push and pop both succeed.
    wready_o = !full || rready_i;
    push     = wvalid_i && wready_o;
    pop      = rvalid_o && rready_i;
    wptr_d   = push ? wptr_q + (AddrW + 1)'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + (AddrW + 1)'(1) : rptr_q;
    rdata_o  = empty ? '0 : mem_q[rptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/spi_target.sv
// Mode-0 MSB-first SPI target with oversampled pins and ready/valid byte streams.
// Define SPI_TARGET_RX_FIFO_EN to replace the single RX holding register with an RxFifoDepth-entry FIFO.
module spi_target
  import spi_target_pkg::*;
#(
  parameter logic [SpiByteW-1:0] TxFill      = 8'hFF,
  parameter int unsigned         RxFifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                spi_sck_i,
  input  logic                spi_cs_ni,
  input  logic                spi_copi_i,
  output logic                spi_cipo_o,
  output logic                spi_cipo_en_o,
  output logic [SpiByteW-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                rx_overrun_o,
  input  logic [SpiByteW-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic                tx_underrun_o,
  output logic                abort_o,
  output logic                active_o
);

  logic [SpiSyncStages:0]   sck_sync_q, cs_sync_q;
  logic [SpiSyncStages-1:0] copi_sync_q;
  logic                     sck_rise, sck_fall, cs_rise, cs_fall, copi_s;

  spi_target_state_e state_q, state_d;
  logic              selected, frame_start, bit_rise, bit_fall, tx_load, abort;

  logic [SpiCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SpiByteW-1:0] rx_shift_q, rx_shift_d;
  logic                push_q, push_d;
  logic [SpiByteW-1:0] tx_shift_q, tx_shift_d;
  logic [SpiByteW-1:0] tx_hold_q, tx_hold_d;
  logic                tx_full_q, tx_full_d;
  logic                tx_underrun_q, tx_underrun_d;
  logic                abort_q;
  logic                rx_overrun_q, rx_overrun_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SpiSyncStages-1:0], spi_sck_i};
      cs_sync_q   <= {cs_sync_q[SpiSyncStages-1:0], spi_cs_ni};
      copi_sync_q <= {copi_sync_q[SpiSyncStages-2:0], spi_copi_i};
    end
  end

  always_comb begin
    sck_rise = sck_sync_q[SpiSyncStages-1] && !sck_sync_q[SpiSyncStages];
    sck_fall = !sck_sync_q[SpiSyncStages-1] && sck_sync_q[SpiSyncStages];
    cs_rise  = cs_sync_q[SpiSyncStages-1] && !cs_sync_q[SpiSyncStages];
    cs_fall  = !cs_sync_q[SpiSyncStages-1] && cs_sync_q[SpiSyncStages];
    copi_s   = copi_sync_q[SpiSyncStages-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cs_fall) state_d = SEL;
      SEL:  if (cs_rise) state_d = IDLE;
    endcase
  end

  // A CS_N rise masks any SCK edge detected in the same cycle.
  always_comb begin
    selected    = (state_q == SEL);
    frame_start = (state_q == IDLE) && cs_fall;
    bit_rise    = selected && sck_rise && !cs_rise;
    bit_fall    = selected && sck_fall && !cs_rise;
    tx_load     = frame_start || (bit_fall && (bit_cnt_q == '0));
    abort       = selected && cs_rise && (bit_cnt_q != '0);
  end

  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    push_d        = 1'b0;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    tx_full_d     = tx_full_q;
    tx_underrun_d = 1'b0;

    if (frame_start || cs_rise) begin
      bit_cnt_d = '0;
    end else if (bit_rise) begin
      bit_cnt_d  = bit_cnt_q + SpiCntW'(1);
      rx_shift_d = {rx_shift_q[SpiByteW-2:0], copi_s};
      push_d     = (bit_cnt_q == '1);
    end

    // Load sees the pre-capture holding register; a same-cycle capture refills it.
    if (tx_load) begin
      tx_shift_d    = tx_full_q ? tx_hold_q : TxFill;
      tx_underrun_d = !tx_full_q;
      tx_full_d     = 1'b0;
    end else if (bit_fall) begin
      tx_shift_d = {tx_shift_q[SpiByteW-2:0], 1'b0};
    end
    if (tx_valid_i && !tx_full_q) begin
      tx_hold_d = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      push_q        <= 1'b0;
      tx_shift_q    <= TxFill;
      tx_hold_q     <= '0;
      tx_full_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      abort_q       <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      push_q        <= push_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      tx_full_q     <= tx_full_d;
      tx_underrun_q <= tx_underrun_d;
      abort_q       <= abort;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

`ifdef SPI_TARGET_RX_FIFO_EN
  logic fifo_wready;

  spi_target_fifo #(
    .Width(SpiByteW),
    .Depth(RxFifoDepth)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wdata_i (rx_shift_q),
    .wvalid_i(push_q),
    .wready_o(fifo_wready),
    .rdata_o (rx_data_o),
    .rvalid_o(rx_valid_o),
    .rready_i(rx_ready_i)
  );

  assign rx_overrun_d = push_q && !fifo_wready;
`else
  logic [SpiByteW-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;
    if (push_q) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
`endif

  assign spi_cipo_o    = tx_shift_q[SpiByteW-1];
  assign spi_cipo_en_o = selected;
  assign active_o      = selected;
  assign tx_ready_o    = !tx_full_q;
  assign tx_underrun_o = tx_underrun_q;
  assign abort_o       = abort_q;
  assign rx_overrun_o  = rx_overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target: SPI controller model driving pins at clk/8.
module tb_spi_target;

`ifdef SPI_TARGET_RX_FIFO_EN
  localparam int NOv = 5;
`else
  localparam int NOv = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sck, cs_n, copi;
  logic       cipo, cipo_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_overrun;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_underrun;
  logic       abort, active;

  int tests = 0;
  int failed = 0;
  int n_under = 0;
  int n_over = 0;
  int n_abort = 0;
  logic [7:0] rxq[$];
  logic [7:0] ov_bytes [5] = '{8'hAA, 8'h55, 8'h66, 8'h77, 8'h88};

  spi_target #(
    .TxFill(8'hFF),
    .RxFifoDepth(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spi_sck_i    (sck),
    .spi_cs_ni    (cs_n),
    .spi_copi_i   (copi),
    .spi_cipo_o   (cipo),
    .spi_cipo_en_o(cipo_en),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rx_ready),
    .rx_overrun_o (rx_overrun),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_underrun_o(tx_underrun),
    .abort_o      (abort),
    .active_o     (active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_underrun) n_under++;
      if (rx_overrun) n_over++;
      if (abort) n_abort++;
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic queue_tx(input logic [7:0] d);
    int budget;
    budget = 50;
    while (!tx_ready && budget > 0) begin
      tick();
      budget--;
    end
    check("queue_tx_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic start_frame(input bit cap, input logic [7:0] cap_data);
    cs_n = 1'b0;
    tick();
    tick();
    check("cipo_en_early", cipo_en, 0);
    if (cap) begin
      tx_data  = cap_data;
      tx_valid = 1'b1;
    end
    tick();
    tx_valid = 1'b0;
    check("cipo_en_on", cipo_en, 1);
    check("active_on", active, 1);
    tick();
  endtask

  // mode 1: check rx_valid latency on the last bit; mode 2: pulse rx_ready in the push cycle.
  task automatic send_bits(input logic [7:0] tx, input int n, input bit last, input int mode,
                           output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      copi = tx[i];
      repeat (4) tick();
      rx[i] = cipo;
      sck = 1'b1;
      if (i == 0 && mode == 1) begin
        repeat (3) tick();
        check("rx_valid_pre", rx_valid, 0);
        tick();
        check("rx_valid_rise", rx_valid, 1);
      end else if (i == 0 && mode == 2) begin
        repeat (3) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end else begin
        repeat (4) tick();
      end
      if (!(last && i == 0)) sck = 1'b0;
    end
  endtask

  task automatic end_frame();
    sck  = 1'b0;
    cs_n = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    int u0, o0, a0, q0;
    sck = 1'b0; cs_n = 1'b1; copi = 1'b0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cipo", cipo, 1);
    check("rst_cipo_en", cipo_en, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_active", active, 0);
    check("rst_pulses", {tx_underrun, rx_overrun, abort}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic transfer
    queue_tx(8'hA5);
    check("basic_tx_ready_full", tx_ready, 0);
    u0 = n_under; q0 = rxq.size();
    start_frame(1'b0, 8'h00);
    check("basic_tx_ready_after_load", tx_ready, 1);
    send_bits(8'h3C, 8, 1'b1, 1, r0);
    end_frame();
    check("basic_cipo", r0, 8'hA5);
    check("basic_rx_data", rx_data, 8'h3C);
    check("basic_rx_valid", rx_valid, 1);
    check("basic_no_underrun", n_under - u0, 0);
    check("basic_idle", {active, cipo_en}, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("basic_rx_popped", rx_valid, 0);
    check("basic_rx_count", rxq.size() - q0, 1);

    // Back-to-back with underrun
    rx_ready = 1'b1;
    queue_tx(8'h11);
    u0 = n_under; q0 = rxq.size();
    start_frame(1'b0, 8'h00);
    send_bits(8'h01, 8, 1'b0, 0, r0);
    send_bits(8'h02, 8, 1'b0, 0, r1);
    send_bits(8'h03, 8, 1'b1, 0, r2);
    end_frame();
    check("b2b_cipo0", r0, 8'h11);
    check("b2b_cipo1", r1, 8'hFF);
    check("b2b_cipo2", r2, 8'hFF);
    check("b2b_underruns", n_under - u0, 2);
    check("b2b_rx_count", rxq.size() - q0, 3);
    check("b2b_rx0", rxq[q0], 8'h01);
    check("b2b_rx1", rxq[q0 + 1], 8'h02);
    check("b2b_rx2", rxq[q0 + 2], 8'h03);

    // Overrun
    rx_ready = 1'b0;
    o0 = n_over; q0 = rxq.size();
    start_frame(1'b0, 8'h00);
    for (int b = 0; b < NOv; b++) send_bits(ov_bytes[b], 8, (b == NOv - 1), 0, r0);
    end_frame();
    check("ovr_pulses", n_over - o0, 1);
    check("ovr_rx_data", rx_data, ov_bytes[0]);
    check("ovr_rx_valid", rx_valid, 1);
    rx_ready = 1'b1;
    repeat (NOv) tick();
    rx_ready = 1'b0;
    check("ovr_rx_count", rxq.size() - q0, NOv - 1);
    for (int b = 0; b < NOv - 1; b++) check("ovr_rx_byte", rxq[q0 + b], ov_bytes[b]);
    check("ovr_drained", rx_valid, 0);

    // Mid-byte abort, then a clean frame
    rx_ready = 1'b1;
    a0 = n_abort; q0 = rxq.size();
    start_frame(1'b0, 8'h00);
    send_bits(8'hFF, 5, 1'b0, 0, r0);
    cs_n = 1'b1;
    repeat (6) tick();
    check("abort_pulses", n_abort - a0, 1);
    check("abort_no_rx", rxq.size() - q0, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_inactive", active, 0);
    start_frame(1'b0, 8'h00);
    send_bits(8'hC3, 8, 1'b1, 0, r0);
    end_frame();
    check("abort_next_count", rxq.size() - q0, 1);
    check("abort_next_data", rxq[q0], 8'hC3);
    check("abort_no_extra", n_abort - a0, 1);

    // Reset mid-transfer
    queue_tx(8'h77);
    start_frame(1'b0, 8'h00);
    send_bits(8'hF0, 3, 1'b0, 0, r0);
    rst_n = 1'b0;
    #1;
    check("mrst_cipo", cipo, 1);
    check("mrst_cipo_en", cipo_en, 0);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_active", active, 0);
    check("mrst_pulses", {tx_underrun, rx_overrun, abort}, 0);
    cs_n = 1'b1; sck = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    queue_tx(8'h5A);
    q0 = rxq.size();
    start_frame(1'b0, 8'h00);
    send_bits(8'h96, 8, 1'b1, 0, r0);
    end_frame();
    check("mrst_next_cipo", r0, 8'h5A);
    check("mrst_next_count", rxq.size() - q0, 1);
    check("mrst_next_data", rxq[q0], 8'h96);

    // Simultaneous TX capture+load and RX push+pop
    u0 = n_under;
    rx_ready = 1'b0;
    start_frame(1'b1, 8'hE7);
    check("sim_tx_captured", tx_ready, 0);
    check("sim_underrun", n_under - u0, 1);
    o0 = n_over; q0 = rxq.size();
    send_bits(8'h12, 8, 1'b0, 0, r0);
    send_bits(8'h34, 8, 1'b1, 2, r1);
    check("sim_rx_data", rx_data, 8'h34);
    check("sim_rx_valid", rx_valid, 1);
    check("sim_no_overrun", n_over - o0, 0);
    check("sim_pop_count", rxq.size() - q0, 1);
    check("sim_pop_data", rxq[q0], 8'h12);
    end_frame();
    check("sim_cipo0", r0, 8'hFF);
    check("sim_cipo1", r1, 8'hE7);
    check("sim_tx_ready_end", tx_ready, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("sim_final_count", rxq.size() - q0, 2);
    check("sim_final_data", rxq[q0 + 1], 8'h34);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
